// File: rtl/l2_rsp_out_pack_pkg.sv
// Shared types and helpers for the L2 response-to-NoC flit packer.
package l2_rsp_out_pack_pkg;

  localparam int MIX_MSG_BITS = 5;

  // Default configuration, used by the fixed-width reference typedefs below
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int DEF_WORD_BITS      = 64;
  localparam int DEF_ID_BITS        = 6;

  typedef enum logic [MIX_MSG_BITS-1:0] {
    MIX_MSG_INV_ACK  = 5'd0,
    MIX_MSG_RSP_S    = 5'd1,
    MIX_MSG_RSP_E    = 5'd2,
    MIX_MSG_RSP_O    = 5'd3,
    MIX_MSG_RSP_V    = 5'd4,
    MIX_MSG_RSP_ODAT = 5'd5,
    MIX_MSG_RSP_WB   = 5'd6,
    MIX_MSG_RSP_NACK = 5'd7
  } mix_msg_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_ADDR,
    ST_DATA
  } pack_state_t;

  // Flit layout: head at the top bit, tail just below it, payload underneath
  typedef struct packed {
    logic                     head;
    logic                     tail;
    logic [DEF_WORD_BITS-1:0] payload;
  } noc_flit_t;

  // Head-flit header, packed MSB-first into the top of the payload
  typedef struct packed {
    logic [DEF_ID_BITS-1:0]        req_id;
    logic [DEF_ID_BITS-1:0]        src_id;
    mix_msg_t                      coh_msg;
    logic [DEF_WORDS_PER_LINE-1:0] word_mask;
  } rsp_pack_hdr_t;

  // Header width for a given id width and line size
  function automatic int rsp_hdr_bits(input int id_bits, input int words);
    return 2 * id_bits + MIX_MSG_BITS + words;
  endfunction

endpackage

// File: rtl/l2_rsp_out_pack_if.sv
// Upstream response channel from l2_core and downstream NoC flit channel.
interface l2_rsp_out_if
  import l2_rsp_out_pack_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int WORD_BITS      = 64,
  parameter int ADDR_BITS      = 32,
  parameter int ID_BITS        = 6
);
  localparam int LINE_ADDR_BITS = ADDR_BITS - $clog2(WORDS_PER_LINE * WORD_BITS / 8);

  logic                                l2_rsp_out_valid;
  logic                                l2_rsp_out_ready;
  logic [MIX_MSG_BITS-1:0]             rsp_coh_msg;
  logic [ID_BITS-1:0]                  rsp_req_id;
  logic [LINE_ADDR_BITS-1:0]           rsp_line_addr;
  logic [WORDS_PER_LINE-1:0]           rsp_word_mask;
  logic                                rsp_has_data;
  logic [WORDS_PER_LINE*WORD_BITS-1:0] rsp_line;

  modport master (
    output l2_rsp_out_valid, rsp_coh_msg, rsp_req_id, rsp_line_addr,
           rsp_word_mask, rsp_has_data, rsp_line,
    input  l2_rsp_out_ready
  );

  modport slave (
    input  l2_rsp_out_valid, rsp_coh_msg, rsp_req_id, rsp_line_addr,
           rsp_word_mask, rsp_has_data, rsp_line,
    output l2_rsp_out_ready
  );
endinterface

interface noc_rsp_if #(
  parameter int WORD_BITS = 64
);
  logic                 noc_valid;
  logic                 noc_ready;
  logic [WORD_BITS+1:0] noc_flit;

  modport master (output noc_valid, noc_flit, input noc_ready);
  modport slave  (input noc_valid, noc_flit, output noc_ready);
endinterface

// File: rtl/l2_rsp_pack_penc.sv
// Lowest-set-bit priority encoder over the remaining word mask.
module l2_rsp_pack_penc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan high to low so the lowest set bit is the last one written
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_rsp_out_pack.sv
// Serializes one L2 response into head, address and per-present-word data flits.
module l2_rsp_out_pack
  import l2_rsp_out_pack_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int WORD_BITS      = 64,
  parameter int ADDR_BITS      = 32,
  parameter int ID_BITS        = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ID_BITS-1:0] my_id,
  l2_rsp_out_if.slave        rsp,
  noc_rsp_if.master          noc
);

  localparam int LINE_ADDR_BITS = ADDR_BITS - $clog2(WORDS_PER_LINE * WORD_BITS / 8);
  localparam int IDX_W          = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int HDR_BITS       = rsp_hdr_bits(ID_BITS, WORDS_PER_LINE);

  typedef struct packed {
    logic                 head;
    logic                 tail;
    logic [WORD_BITS-1:0] payload;
  } flit_t;

  pack_state_t                              state;
  logic                                     rdy_q;
  logic                                     vld_q;
  flit_t                                    flit_q;
  logic [LINE_ADDR_BITS-1:0]                msg_line_addr;
  logic [WORDS_PER_LINE-1:0][WORD_BITS-1:0] msg_words;
  logic [WORDS_PER_LINE-1:0]                rem_mask;
  logic [WORDS_PER_LINE-1:0]                rem_clr;
  logic [IDX_W-1:0]                         cur_idx, nxt_idx;
  logic                                     cur_found, nxt_found;
  logic [HDR_BITS-1:0]                      hdr;
  logic [WORD_BITS-1:0]                     hdr_payload;

  // cur: word on the wire now (DATA) or the first data word (ADDR).
  // nxt: the word after it, i.e. lowest bit once cur is retired.
  l2_rsp_pack_penc #(.N(WORDS_PER_LINE), .IDX_W(IDX_W)) u_penc_cur (
    .mask  (rem_mask),
    .idx   (cur_idx),
    .found (cur_found)
  );

  assign rem_clr = rem_mask & ~(WORDS_PER_LINE'(1) << cur_idx);

  l2_rsp_pack_penc #(.N(WORDS_PER_LINE), .IDX_W(IDX_W)) u_penc_nxt (
    .mask  (rem_clr),
    .idx   (nxt_idx),
    .found (nxt_found)
  );

  // Header is formed from the live inputs only on the capture cycle
  assign hdr         = {rsp.rsp_req_id, my_id, rsp.rsp_coh_msg, rsp.rsp_word_mask};
  assign hdr_payload = {hdr, {(WORD_BITS - HDR_BITS){1'b0}}};

  assign rsp.l2_rsp_out_ready = rdy_q;
  assign noc.noc_valid        = vld_q;
  assign noc.noc_flit         = flit_q;

  // FSM: each state preloads the flit for the state it moves to, so outputs stay registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      rdy_q         <= 1'b0;
      vld_q         <= 1'b0;
      flit_q        <= '0;
      msg_line_addr <= '0;
      msg_words     <= '0;
      rem_mask      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rsp.l2_rsp_out_valid && rdy_q) begin
            msg_line_addr <= rsp.rsp_line_addr;
            msg_words     <= rsp.rsp_line;
            rem_mask      <= rsp.rsp_has_data ? rsp.rsp_word_mask : '0;
            rdy_q         <= 1'b0;
            vld_q         <= 1'b1;
            flit_q        <= '{head: 1'b1, tail: 1'b0, payload: hdr_payload};
            state         <= ST_HEAD;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        ST_HEAD: begin
          if (noc.noc_ready) begin
            flit_q <= '{head: 1'b0, tail: !cur_found, payload: WORD_BITS'(msg_line_addr)};
            state  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (noc.noc_ready) begin
            if (!cur_found) begin
              vld_q  <= 1'b0;
              flit_q <= '0;
              rdy_q  <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              flit_q <= '{head: 1'b0, tail: !nxt_found, payload: msg_words[cur_idx]};
              state  <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (noc.noc_ready) begin
            rem_mask <= rem_clr;
            if (!nxt_found) begin
              vld_q  <= 1'b0;
              flit_q <= '0;
              rdy_q  <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              // Next word is the last one when only a single bit remains after it
              flit_q <= '{head:    1'b0,
                          tail:    (rem_clr & (rem_clr - WORDS_PER_LINE'(1))) == '0,
                          payload: msg_words[nxt_idx]};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_rsp_out_pack.sv
// Randomized and directed bench for l2_rsp_out_pack against a flit-list reference model.
module tb_l2_rsp_out_pack;

  localparam int W   = 4;
  localparam int WB  = 64;
  localparam int AB  = 32;
  localparam int IDB = 6;
  localparam int LAB = 27;
  localparam int FW  = WB + 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [IDB-1:0] my_id;

  always #5 clk = ~clk;

  l2_rsp_out_if #(.WORDS_PER_LINE(W), .WORD_BITS(WB), .ADDR_BITS(AB), .ID_BITS(IDB)) rsp_if ();
  noc_rsp_if #(.WORD_BITS(WB)) noc_if ();

  l2_rsp_out_pack #(.WORDS_PER_LINE(W), .WORD_BITS(WB), .ADDR_BITS(AB), .ID_BITS(IDB)) dut (
    .clk   (clk),
    .rst   (rst),
    .my_id (my_id),
    .rsp   (rsp_if),
    .noc   (noc_if)
  );

  int            errs = 0;
  int            checks = 0;
  int            ncyc = 0;
  int            last_tail = 0;
  int            rdy_mode = 0;
  int            hs1, hs2, hs;
  logic [FW-1:0] exp_q[$];
  logic          stall = 1'b0;
  logic [FW-1:0] prev_flit = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: a response becomes head, address, then one flit per present word, low index first
  task automatic push_exp(input logic [4:0] msg, input logic [IDB-1:0] req, input logic [LAB-1:0] addr,
                          input logic [W-1:0] mask, input logic hd, input logic [W*WB-1:0] line);
    logic [WB-1:0] p;
    int nd, cnt;
    p = (64'(req) << 58) | (64'(my_id) << 52) | (64'(msg) << 47) | (64'(mask) << 43);
    nd = 0;
    for (int i = 0; i < W; i++) if (hd && mask[i]) nd++;
    exp_q.push_back({1'b1, 1'b0, p});
    exp_q.push_back({1'b0, (nd == 0), 64'(addr)});
    cnt = 0;
    for (int i = 0; i < W; i++) begin
      if (hd && mask[i]) begin
        cnt++;
        exp_q.push_back({1'b0, (cnt == nd), line[i*WB +: WB]});
      end
    end
  endtask

  function automatic logic [W*WB-1:0] mk_line(input logic [WB-1:0] base);
    logic [W*WB-1:0] l;
    for (int i = 0; i < W; i++) l[i*WB +: WB] = base + 64'(i);
    return l;
  endfunction

  function automatic logic [W*WB-1:0] rnd_line();
    logic [W*WB-1:0] l;
    for (int i = 0; i < W * WB / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic scramble();
    rsp_if.rsp_coh_msg   = 5'($urandom);
    rsp_if.rsp_req_id    = IDB'($urandom);
    rsp_if.rsp_line_addr = LAB'($urandom);
    rsp_if.rsp_word_mask = W'($urandom);
    rsp_if.rsp_has_data  = 1'($urandom);
    rsp_if.rsp_line      = rnd_line();
  endtask

  // One clock: drive noc_ready after the falling edge, then sample and score the wire
  task automatic tick();
    logic [FW-1:0] e;
    @(negedge clk);
    ncyc++;
    case (rdy_mode)
      1:       noc_if.noc_ready = ($urandom_range(0, 3) != 0);
      2:       noc_if.noc_ready = 1'b0;
      default: noc_if.noc_ready = 1'b1;
    endcase
    #1;
    if (!rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", noc_if.noc_valid, 1);
        chk("hold_flit", noc_if.noc_flit, prev_flit);
      end
      if (noc_if.noc_valid && noc_if.noc_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_flit", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("flit", noc_if.noc_flit, e);
          if (e[WB]) last_tail = ncyc;
        end
      end
      stall     = noc_if.noc_valid && !noc_if.noc_ready;
      prev_flit = noc_if.noc_flit;
    end
  endtask

  task automatic send(input logic [4:0] msg, input logic [IDB-1:0] req, input logic [LAB-1:0] addr,
                      input logic [W-1:0] mask, input logic hd, input logic [W*WB-1:0] line,
                      output int hs_cyc);
    int n;
    n = 0;
    rsp_if.rsp_coh_msg      = msg;
    rsp_if.rsp_req_id       = req;
    rsp_if.rsp_line_addr    = addr;
    rsp_if.rsp_word_mask    = mask;
    rsp_if.rsp_has_data     = hd;
    rsp_if.rsp_line         = line;
    rsp_if.l2_rsp_out_valid = 1'b1;
    while (!rsp_if.l2_rsp_out_ready && n < 200) begin
      tick();
      n++;
    end
    chk("hs_wait", rsp_if.l2_rsp_out_ready, 1);
    hs_cyc = ncyc;
    push_exp(msg, req, addr, mask, hd, line);
    tick();
    rsp_if.l2_rsp_out_valid = 1'b0;
    scramble();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !rsp_if.l2_rsp_out_ready) && n < 500) begin
      tick();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    my_id = IDB'($urandom);
    rsp_if.l2_rsp_out_valid = 1'b0;
    noc_if.noc_ready = 1'b1;
    scramble();

    // Reset state
    repeat (3) tick();
    chk("rst_ready", rsp_if.l2_rsp_out_ready, 0);
    chk("rst_valid", noc_if.noc_valid, 0);
    chk("rst_flit", noc_if.noc_flit, 0);
    rst = 1'b1;
    tick();
    chk("idle_ready", rsp_if.l2_rsp_out_ready, 1);
    chk("idle_valid", noc_if.noc_valid, 0);

    // No data, full mask: two flits, ready back three cycles after the handshake
    send(5'd1, 6'd3, 27'h0ABCDEF, 4'hF, 1'b0, mk_line(64'hA0), hs);
    n = 0;
    while (!rsp_if.l2_rsp_out_ready && n < 50) begin
      tick();
      n++;
    end
    chk("rdy_back", ncyc - hs, 3);
    drain();

    // Full line, partial line, and data flag with empty mask
    send(5'd5, 6'd12, 27'h1234567, 4'hF, 1'b1, mk_line(64'hA0), hs);
    drain();
    send(5'd2, 6'd33, 27'h7FFFFFF, 4'b1010, 1'b1, mk_line(64'hB0), hs);
    drain();
    send(5'd4, 6'd63, 27'h0000001, 4'b0000, 1'b1, mk_line(64'hC0), hs);
    drain();

    // Stall five cycles while the first data flit is on the wire
    send(5'd3, 6'd7, 27'h0055AA5, 4'b1101, 1'b1, mk_line(64'hD0), hs);
    tick();
    rdy_mode = 2;
    repeat (5) tick();
    rdy_mode = 0;
    drain();

    // Back-to-back full responses
    send(5'd5, 6'd1, 27'h0000100, 4'hF, 1'b1, mk_line(64'hE0), hs1);
    send(5'd6, 6'd2, 27'h0000200, 4'hF, 1'b1, mk_line(64'hF0), hs2);
    chk("b2b_gap", hs2 - last_tail, 1);
    drain();
    chk("b2b_span", last_tail - hs1, 13);

    // Reset while in DATA abandons the packet
    send(5'd5, 6'd9, 27'h0300300, 4'hF, 1'b1, mk_line(64'h110), hs);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", noc_if.noc_valid, 0);
    chk("mid_rst_ready", rsp_if.l2_rsp_out_ready, 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("post_mid_rst_ready", rsp_if.l2_rsp_out_ready, 1);
    send(5'd1, 6'd10, 27'h0400400, 4'b1010, 1'b1, mk_line(64'h220), hs);
    drain();

    // Random traffic with random back-pressure
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      send(5'($urandom), IDB'($urandom), LAB'($urandom), W'($urandom), 1'($urandom), rnd_line(), hs);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rdy_mode = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
